// File: rtl/m3_step_sequencer.sv
// m3_step_sequencer: 3-phase commutation step generator for the motoro3 drive.
// Phase A walks 1..STEPS (forward) or STEPS..1 (reverse), one position per
// P = max(m3period, 2) clocks; B and C follow A at +STEPS/3 and +2*STEPS/3.
// State changes on the falling clock edge; nRst clears everything asynchronously.
// Optional build macro M3_SOFTSTART_EN: the first electrical cycle runs at 4P
// per step, the second at 2P, then P (shifted reloads saturate to all-ones).
`timescale 1ns/1ps
module m3_step_sequencer #(
  parameter int unsigned STEPS = 6,
  parameter int unsigned PH_W  = 4,
  parameter int unsigned CNT_W = 25,
  parameter int unsigned TGT_W = 16,
  parameter int unsigned RND_W = 32
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             m3start,
  input  logic             m3abort,
  input  logic             m3dir,
  input  logic [CNT_W-1:0] m3period,
  input  logic [TGT_W-1:0] m3target,
  output logic [PH_W-1:0]  m3stepA,
  output logic [PH_W-1:0]  m3stepB,
  output logic [PH_W-1:0]  m3stepC,
  output logic [CNT_W-1:0] m3cnt,
  output logic             m3cntLast1,
  output logic             m3busy,
  output logic             m3done,
  output logic [RND_W-1:0] m3round
);

  if ((STEPS % 3) != 0 || STEPS < 3) begin : g_bad_steps
    $error("m3_step_sequencer: STEPS must be a multiple of 3 and at least 3");
  end
  if ((2 ** PH_W) <= (STEPS + 1)) begin : g_bad_ph_w
    $error("m3_step_sequencer: PH_W too narrow for STEPS+1");
  end

  localparam logic [PH_W-1:0] STEP_IDLE  = '0;
  localparam logic [PH_W-1:0] STEP_FIRST = PH_W'(1);
  localparam logic [PH_W-1:0] STEP_LAST  = PH_W'(STEPS);
  localparam logic [PH_W-1:0] STEP_FSTOP = PH_W'(STEPS + 1);
  localparam logic [PH_W:0]   STEPS_W    = (PH_W+1)'(STEPS);
  localparam logic [PH_W:0]   OFS_B      = (PH_W+1)'(STEPS / 3);
  localparam logic [PH_W:0]   OFS_C      = (PH_W+1)'((2 * STEPS) / 3);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FSTOP} state_t;

  state_t           state_q;
  logic [PH_W-1:0]  step_q;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;
  logic [RND_W-1:0] round_q;
  logic             start_d_q;
  logic [TGT_W-1:0] stepcnt_q;
  logic [TGT_W-1:0] target_q;
`ifdef M3_SOFTSTART_EN
  logic [1:0]       sh_q;
  logic [1:0]       sh_d;
`endif

  logic             start_up;
  logic             at_boundary;
  logic             wrap;
  logic             running;
  logic             tgt_hit;
  logic [CNT_W-1:0] p_eff;
  logic [CNT_W-1:0] reload_start;
  logic [CNT_W-1:0] reload_adv;
  logic [PH_W-1:0]  step_adv;
  logic [TGT_W-1:0] stepcnt_inc;

  // Offset a live phase-A position by ofs within 1..STEPS; idle/stop codes pass through.
  function automatic logic [PH_W-1:0] phase_of(input logic [PH_W-1:0] a,
                                               input logic [PH_W:0]   ofs);
    logic [PH_W:0] sum;
    if (a == STEP_IDLE || a == STEP_FSTOP) return a;
    sum = {1'b0, a} + ofs;
    if (sum > STEPS_W) sum = sum - STEPS_W;
    return sum[PH_W-1:0];
  endfunction

`ifdef M3_SOFTSTART_EN
  // P << sh, saturating to all-ones when the result no longer fits CNT_W.
  function automatic logic [CNT_W-1:0] shl_sat(input logic [CNT_W-1:0] p,
                                               input logic [1:0]       sh);
    logic [CNT_W+1:0] wide;
    wide = {2'b00, p} << sh;
    if (wide[CNT_W+1:CNT_W] != 2'b00) return '1;
    return wide[CNT_W-1:0];
  endfunction
`endif

  // Next-step position, wrap detection, target match and counter reload values.
  always_comb begin
    start_up    = m3start & ~start_d_q;
    p_eff       = (m3period < CNT_W'(2)) ? CNT_W'(2) : m3period;
    at_boundary = (cnt_q == '0);
    if (m3dir) begin
      wrap     = (step_q == STEP_FIRST);
      step_adv = wrap ? STEP_LAST : step_q - STEP_FIRST;
    end else begin
      wrap     = (step_q == STEP_LAST);
      step_adv = wrap ? STEP_FIRST : step_q + STEP_FIRST;
    end
    stepcnt_inc = stepcnt_q + TGT_W'(1);
    tgt_hit     = (target_q != '0) && (stepcnt_inc == target_q);
    // A start edge while draining resumes stepping in the same clock.
    running     = (state_q == S_RUN) || ((state_q == S_DRAIN) && start_up);
`ifdef M3_SOFTSTART_EN
    sh_d         = (wrap && sh_q != 2'd0) ? sh_q - 2'd1 : sh_q;
    reload_start = shl_sat(p_eff, 2'd2) - CNT_W'(1);
    reload_adv   = shl_sat(p_eff, sh_d) - CNT_W'(1);
`else
    reload_start = p_eff - CNT_W'(1);
    reload_adv   = reload_start;
`endif
  end

  // Sequencer FSM: IDLE / RUN / DRAIN / FSTOP with step, counter and round state.
  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q   <= S_IDLE;
      step_q    <= STEP_IDLE;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      round_q   <= '0;
      start_d_q <= 1'b0;
      stepcnt_q <= '0;
      target_q  <= '0;
`ifdef M3_SOFTSTART_EN
      sh_q      <= 2'd0;
`endif
    end else begin
      start_d_q <= m3start;
      done_q    <= 1'b0;
      if (m3abort) begin
        state_q <= S_FSTOP;
        step_q  <= STEP_FSTOP;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            step_q <= STEP_IDLE;
            cnt_q  <= '0;
            if (start_up) begin
              state_q   <= S_RUN;
              step_q    <= STEP_FIRST;
              cnt_q     <= reload_start;
              stepcnt_q <= '0;
              round_q   <= '0;
              target_q  <= m3target;
`ifdef M3_SOFTSTART_EN
              sh_q      <= 2'd2;
`endif
            end
          end
          S_RUN, S_DRAIN: begin
            if (running) begin
              if (at_boundary) begin
                stepcnt_q <= stepcnt_inc;
                if (wrap) round_q <= round_q + RND_W'(1);
`ifdef M3_SOFTSTART_EN
                sh_q      <= sh_d;
`endif
                if (tgt_hit) begin
                  done_q  <= 1'b1;
                  step_q  <= STEP_IDLE;
                  state_q <= S_IDLE;
                end else begin
                  step_q  <= step_adv;
                  cnt_q   <= reload_adv;
                  state_q <= m3start ? S_RUN : S_DRAIN;
                end
              end else begin
                cnt_q   <= cnt_q - CNT_W'(1);
                state_q <= m3start ? S_RUN : S_DRAIN;
              end
            end else if (at_boundary) begin
              state_q <= S_IDLE;
              step_q  <= STEP_IDLE;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          S_FSTOP: begin
            step_q <= STEP_FSTOP;
            cnt_q  <= '0;
            if (!m3start) begin
              state_q <= S_IDLE;
              step_q  <= STEP_IDLE;
            end
          end
          default: begin
            state_q <= S_IDLE;
            step_q  <= STEP_IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign m3stepA    = step_q;
  assign m3stepB    = phase_of(step_q, OFS_B);
  assign m3stepC    = phase_of(step_q, OFS_C);
  assign m3cnt      = cnt_q;
  assign m3busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign m3cntLast1 = m3busy && (cnt_q == '0);
  assign m3done     = done_q;
  assign m3round    = round_q;

endmodule

// File: tb/tb_m3_step_sequencer.sv
// Bench for m3_step_sequencer: directed scenarios followed by a random walk of
// start/abort/dir/period/target, every clock compared against a behavioural model
// that tracks position (0-based), clocks remaining in the step and run mode.
`timescale 1ns/1ps
module tb_m3_step_sequencer;
  localparam int STEPS = 6;
  localparam int PH_W  = 4;
  localparam int CNT_W = 25;
  localparam int TGT_W = 16;
  localparam int RND_W = 32;

  logic             clk;
  logic             nRst;
  logic             m3start;
  logic             m3abort;
  logic             m3dir;
  logic [CNT_W-1:0] m3period;
  logic [TGT_W-1:0] m3target;
  logic [PH_W-1:0]  m3stepA;
  logic [PH_W-1:0]  m3stepB;
  logic [PH_W-1:0]  m3stepC;
  logic [CNT_W-1:0] m3cnt;
  logic             m3cntLast1;
  logic             m3busy;
  logic             m3done;
  logic [RND_W-1:0] m3round;

  m3_step_sequencer #(
    .STEPS(STEPS), .PH_W(PH_W), .CNT_W(CNT_W), .TGT_W(TGT_W), .RND_W(RND_W)
  ) dut (
    .clk(clk), .nRst(nRst), .m3start(m3start), .m3abort(m3abort), .m3dir(m3dir),
    .m3period(m3period), .m3target(m3target), .m3stepA(m3stepA), .m3stepB(m3stepB),
    .m3stepC(m3stepC), .m3cnt(m3cnt), .m3cntLast1(m3cntLast1), .m3busy(m3busy),
    .m3done(m3done), .m3round(m3round)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef enum int {M_IDLE, M_RUN, M_DRAIN, M_FSTOP} mmode_t;
  mmode_t      mmode = M_IDLE;
  int          mpos = 0;
  int          mrem = 0;
  int          mcount = 0;
  int          mtarget = 0;
  int          msh = 0;
  int unsigned mround = 0;
  bit          mdone = 1'b0;
  bit          mprev = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int step_len();
    int p;
    p = (m3period < 2) ? 2 : int'(m3period);
`ifdef M3_SOFTSTART_EN
    return p << msh;
`else
    return p;
`endif
  endfunction

  task automatic advance();
    bit wrapped;
    if (!m3dir) begin
      mpos    = (mpos + 1) % STEPS;
      wrapped = (mpos == 0);
    end else begin
      wrapped = (mpos == 0);
      mpos    = (mpos + STEPS - 1) % STEPS;
    end
    if (wrapped) begin
      mround++;
      if (msh > 0) msh--;
    end
  endtask

  task automatic model_clk();
    bit su;
    su    = m3start && !mprev;
    mprev = m3start;
    mdone = 1'b0;
    if (m3abort) mmode = M_FSTOP;
    else begin
      case (mmode)
        M_IDLE: if (su) begin
          mmode = M_RUN; mpos = 0; mcount = 0; mround = 0;
          mtarget = int'(m3target); msh = 2; mrem = step_len();
        end
        M_RUN, M_DRAIN: begin
          if (mmode == M_RUN || su) begin
            if (mrem == 1) begin
              advance();
              mcount++;
              if (mtarget != 0 && mcount == mtarget) begin
                mdone = 1'b1; mmode = M_IDLE;
              end else begin
                mrem = step_len(); mmode = m3start ? M_RUN : M_DRAIN;
              end
            end else begin
              mrem--; mmode = m3start ? M_RUN : M_DRAIN;
            end
          end else if (mrem == 1) mmode = M_IDLE;
          else mrem--;
        end
        M_FSTOP: if (!m3start) mmode = M_IDLE;
        default: mmode = M_IDLE;
      endcase
    end
  endtask

  task automatic check_outputs();
    int eA, eB, eC, ecnt;
    bit ebusy, elast;
    case (mmode)
      M_IDLE:  begin eA = 0;         ecnt = 0;        ebusy = 1'b0; end
      M_FSTOP: begin eA = STEPS + 1; ecnt = 0;        ebusy = 1'b0; end
      default: begin eA = mpos + 1;  ecnt = mrem - 1; ebusy = 1'b1; end
    endcase
    eB    = ebusy ? ((mpos + STEPS / 3) % STEPS) + 1 : eA;
    eC    = ebusy ? ((mpos + 2 * STEPS / 3) % STEPS) + 1 : eA;
    elast = ebusy && (mrem == 1);
    chk("stepA", 64'(m3stepA), 64'(eA));
    chk("stepB", 64'(m3stepB), 64'(eB));
    chk("stepC", 64'(m3stepC), 64'(eC));
    chk("cnt", 64'(m3cnt), 64'(ecnt));
    chk("cntLast1", 64'(m3cntLast1), 64'(elast));
    chk("busy", 64'(m3busy), 64'(ebusy));
    chk("done", 64'(m3done), 64'(mdone));
    chk("round", 64'(m3round), 64'(mround));
  endtask

  task automatic cycle();
    @(negedge clk);
    model_clk();
    @(posedge clk);
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_idle();
    m3start = 1'b0;
    m3abort = 1'b0;
    for (int i = 0; i < 300 && mmode != M_IDLE; i++) cycle();
    if (mmode != M_IDLE) begin
      errors++;
      $display("FAIL idle_timeout observed=not_idle expected=idle");
    end
    cycle();
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_stepA"}, 64'(m3stepA), 64'd0);
    chk({tag, "_stepB"}, 64'(m3stepB), 64'd0);
    chk({tag, "_stepC"}, 64'(m3stepC), 64'd0);
    chk({tag, "_cnt"}, 64'(m3cnt), 64'd0);
    chk({tag, "_last1"}, 64'(m3cntLast1), 64'd0);
    chk({tag, "_busy"}, 64'(m3busy), 64'd0);
    chk({tag, "_done"}, 64'(m3done), 64'd0);
    chk({tag, "_round"}, 64'(m3round), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int abort_hold;
    nRst = 1'b0; m3start = 1'b0; m3abort = 1'b0; m3dir = 1'b0;
    m3period = CNT_W'(4); m3target = '0;
    #1;
    reset_checks("reset");
    #200;
    @(posedge clk);
    #5 nRst = 1'b1;
    run(2);

    // Forward, P=4, unlimited
    m3start = 1'b1; m3period = CNT_W'(4); m3dir = 1'b0; m3target = '0;
    cycle();
    chk("first_A", 64'(m3stepA), 64'd1);
    chk("first_B", 64'(m3stepB), 64'd3);
    chk("first_C", 64'(m3stepC), 64'd5);
    run(30);
    wait_idle();

    // Reverse, P=3, dir toggled mid-step
    m3dir = 1'b1; m3period = CNT_W'(3); m3start = 1'b1;
    run(22);
    m3dir = 1'b0; run(4);
    m3dir = 1'b1; run(8);
    wait_idle();

    // Target of 5 steps at P=2, hold then re-trigger
    m3dir = 1'b0; m3period = CNT_W'(2); m3target = TGT_W'(5); m3start = 1'b1;
    run(16);
    m3start = 1'b0; cycle();
    m3start = 1'b1; run(6);
    wait_idle();

    // Drop start at cnt=2 of step 3 with P=6, re-raise during drain
    m3target = '0; m3period = CNT_W'(6); m3start = 1'b1;
    for (int i = 0; i < 200 && !(mmode == M_RUN && mpos == 2 && mrem == 3); i++) cycle();
    m3start = 1'b0; cycle();
    m3start = 1'b1; run(12);
    m3start = 1'b0; run(10);
    wait_idle();

    // Abort mid-step; FSTOP held while start stays high
    m3period = CNT_W'(4); m3start = 1'b1;
    run(5);
    m3abort = 1'b1; cycle();
    m3abort = 1'b0; run(4);
    m3start = 1'b0; run(2);
    wait_idle();

    // Period 0 and 1 clamp to 2 clocks per step
    m3period = '0; m3start = 1'b1; run(8);
    wait_idle();
    m3period = CNT_W'(1); m3start = 1'b1; run(8);
    wait_idle();

    // Long run covering any soft-start ramp
    m3period = CNT_W'(4); m3start = 1'b1; run(160);
    wait_idle();

    // Asynchronous reset in the middle of a run
    m3period = CNT_W'(3); m3start = 1'b1; run(7);
    @(posedge clk);
    #10 nRst = 1'b0;
    #1 reset_checks("midreset");
    mmode = M_IDLE; mround = 0; mdone = 1'b0; mprev = 1'b0;
    #20 nRst = 1'b1;
    run(5);
    wait_idle();

    // Random walk
    abort_hold = 0;
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = int'($urandom_range(99, 0));
      if (abort_hold > 0) abort_hold--;
      else begin
        m3abort = 1'b0;
        if (r < 2) begin m3abort = 1'b1; abort_hold = int'($urandom_range(2, 0)); end
      end
      if ($urandom_range(99, 0) < 6) m3start = ~m3start;
      if ($urandom_range(99, 0) < 8) m3dir = ~m3dir;
      if ($urandom_range(99, 0) < 6) m3period = CNT_W'($urandom_range(6, 0));
      if ($urandom_range(99, 0) < 4) m3target = TGT_W'($urandom_range(9, 0));
      cycle();
    end
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
